lynx_ce_gen: RTL and testbench
==============================

# lynx_ce_gen

Parametrised multi-channel clock-enable generator for the Lynx core. It replaces the fixed free-running pixel, CRTC and CPU enable dividers with per-channel runtime-programmable divisors, paired positive/negative phase strobes and per-channel stall (wait-state) inputs. It also provides a global phase-align strobe. It sits at the top level beside the CPU, CRTC, video and RAM blocks and drives all of their enables from the single master clock.

## Interface
- CHANNELS, 3: number of independent enable channels.
- DIVW, 6: divisor register width; channel period = divisor + 1 master clocks (1..2^DIVW).
- DIV_INIT, {6'd11, 6'd63, 6'd7}: packed CHANNELS*DIVW reset divisors; channel i at [i*DIVW +: DIVW] (ch0 pixel /8, ch1 CRTC /64, ch2 CPU /12).

Ports:
- clock  in  1  master clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- stall  in  CHANNELS  per-channel hold; bit high freezes that channel's counter and suppresses its strobes.
- align  in  1  single-cycle request to restart all channels at phase 0.
- cfg_we  in  1  divisor write strobe.
- cfg_sel  in  $clog2(CHANNELS)  channel to write; values >= CHANNELS are ignored.
- cfg_div  in  DIVW  new divisor (period-1).
- ce_p  out  CHANNELS  positive-phase enable, one clock wide.
- ce_n  out  CHANNELS  negative-phase enable, one clock wide.
- cfg_busy  out  CHANNELS  bit high while a written divisor is pending, not yet active.

## Operation
- Per channel: cnt (DIVW bits), div_act (active divisor), div_sh (shadow), pend flag.
- Reset: cnt=0, div_act=div_sh=DIV_INIT slice, pend=0, ce_p=ce_n=0, cfg_busy=0.
- Normal edge, stall low: ce_p <= (cnt==div_act); ce_n <= (cnt==div_act>>1); cnt <= (cnt==div_act) ? 0 : cnt+1.
- div_act=0: both ce_p and ce_n high every cycle. div_act=1: ce_p and ce_n alternate.
- Stall high: cnt holds; ce_p and ce_n <= 0. The strobe resumes from the held count when stall drops, so no strobe is lost or duplicated.
- cfg write: div_sh <= cfg_div; pend <= 1. A second write before apply overwrites div_sh; only the last write takes effect.
- Apply: on a non-stalled wrap edge (cnt==div_act) with pend already set before that edge, div_act <= div_sh and pend <= 0.
- A write on the same edge as a wrap is not applied at that wrap; it is applied at the next wrap. Counting never glitches mid-period.
- Align, priority over stall and normal counting:
  - all cnt <= 0; all ce_p and ce_n <= 0.
  - Every pending shadow is applied immediately; pend <= 0.
  - A cfg write on the same edge as align is captured as pending, not applied by that align.
- cfg_busy = pend (registered).

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- After reset release, the first ce_p rises after edge div_act+1 and stays high exactly one cycle. The first ce_n rises after edge (div_act>>1)+1.
- Steady-state strobe period: div_act+1 clocks plus one clock per stalled cycle.
- cfg_busy rises one clock after the cfg_we edge and falls in the cycle following the applying wrap or align.
- After an align edge: strobes are low for one cycle, then the phase sequence restarts as after reset.
- Reset asserted mid-period: outputs drop to 0 asynchronously; any pending configuration is discarded.

## Structure
- Package lynx_clk_pkg holds:
  - CE_DIV_PIX=7, CE_DIV_CRTC=63, CE_DIV_CPU=11.
  - Channel indices CE_PIX=0, CE_CRTC=1, CE_CPU=2.
  - Default DIVW=6.
- Sub-module lynx_ce_chan implements one channel (counter, shadow, pend, strobes). The top instantiates it CHANNELS times in a generate loop; cfg_we decoding per channel lives in the top.

## Test plan
- Defaults: release reset, run 128 clocks -> ce_p[0] every 8 clocks (first after edge 8), ce_p[1] every 64, ce_p[2] every 12; ce_n[2] first after edge 6.
- Reprogram: write cfg_sel=2, cfg_div=5 at cnt=3 -> cfg_busy[2]=1; the current 12-clock period completes; thereafter period is 6; cfg_busy[2] clears after the wrap.
- Write-on-wrap: write cfg_sel=0, cfg_div=3 on the exact wrap edge -> one more 8-clock period, then 4-clock periods.
- Stall: hold stall[2] high for 5 clocks mid-period -> no ce_p[2] or ce_n[2] during the stall; that period lengthens to exactly 17 clocks.
- Align: pulse align with a pending write on ch1 (cfg_div=31) -> all strobes low for one clock, then all channels restart from cnt=0 with ch1 period 32 and cfg_busy=0.
- Reset mid-run: assert reset with pend set -> outputs 0 immediately; after release, DIV_INIT periods are restored and cfg_busy=0.

Source files
------------

// File: rtl/lynx_clk_pkg.sv
// Shared constants for the Lynx clock-enable generator: default divisors,
// channel indices and the packed reset-divisor vector.
package lynx_clk_pkg;

  localparam int CE_DIVW     = 6;
  localparam int CE_CHANNELS = 3;

  localparam logic [CE_DIVW-1:0] CE_DIV_PIX  = 6'd7;
  localparam logic [CE_DIVW-1:0] CE_DIV_CRTC = 6'd63;
  localparam logic [CE_DIVW-1:0] CE_DIV_CPU  = 6'd11;

  localparam int CE_PIX  = 0;
  localparam int CE_CRTC = 1;
  localparam int CE_CPU  = 2;

  // Channel i occupies [i*CE_DIVW +: CE_DIVW].
  localparam logic [CE_CHANNELS*CE_DIVW-1:0] CE_DIV_INIT =
    {CE_DIV_CPU, CE_DIV_CRTC, CE_DIV_PIX};

endpackage

// File: rtl/lynx_ce_chan.sv
// One enable channel: period counter, shadowed divisor with pending flag,
// and registered positive/negative phase strobes.
module lynx_ce_chan
  import lynx_clk_pkg::*;
#(
  parameter int              DIVW    = CE_DIVW,
  parameter logic [DIVW-1:0] DIV_RST = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            align,
  input  logic            we,
  input  logic [DIVW-1:0] div_in,
  output logic            ce_p,
  output logic            ce_n,
  output logic            busy
);

  logic [DIVW-1:0] cnt;
  logic [DIVW-1:0] div_act;
  logic [DIVW-1:0] div_sh;
  logic            pend;
  logic            wrap;
  logic            half;

  assign wrap = (cnt == div_act);
  assign half = (cnt == (div_act >> 1));
  assign busy = pend;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      div_act <= DIV_RST;
      div_sh  <= DIV_RST;
      pend    <= 1'b0;
      ce_p    <= 1'b0;
      ce_n    <= 1'b0;
    end else if (align) begin
      // Old shadow applies now; a write on this edge stays pending.
      cnt  <= '0;
      ce_p <= 1'b0;
      ce_n <= 1'b0;
      if (pend) div_act <= div_sh;
      pend <= we;
      if (we) div_sh <= div_in;
    end else begin
      if (stall) begin
        ce_p <= 1'b0;
        ce_n <= 1'b0;
      end else begin
        ce_p <= wrap;
        ce_n <= half;
        cnt  <= wrap ? '0 : cnt + DIVW'(1);
        if (wrap && pend) begin
          div_act <= div_sh;
          pend    <= 1'b0;
        end
      end
      // A write on a wrap edge overrides the clear, deferring it one period.
      if (we) begin
        div_sh <= div_in;
        pend   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/lynx_ce_gen.sv
// Multi-channel clock-enable generator: one lynx_ce_chan per channel with
// the configuration write strobe decoded by channel select.
module lynx_ce_gen
  import lynx_clk_pkg::*;
#(
  parameter int                         CHANNELS = CE_CHANNELS,
  parameter int                         DIVW     = CE_DIVW,
  parameter logic [CHANNELS*DIVW-1:0]   DIV_INIT = CE_DIV_INIT
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          stall,
  input  logic                         align,
  input  logic                         cfg_we,
  input  logic [$clog2(CHANNELS)-1:0]  cfg_sel,
  input  logic [DIVW-1:0]              cfg_div,
  output logic [CHANNELS-1:0]          ce_p,
  output logic [CHANNELS-1:0]          ce_n,
  output logic [CHANNELS-1:0]          cfg_busy
);

  localparam int SELW = $clog2(CHANNELS);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic we;
    // Select values beyond the last channel match nothing and are dropped.
    assign we = cfg_we && (cfg_sel == SELW'(i));

    lynx_ce_chan #(
      .DIVW    (DIVW),
      .DIV_RST (DIV_INIT[i*DIVW +: DIVW])
    ) u_chan (
      .clock  (clock),
      .reset  (reset),
      .stall  (stall[i]),
      .align  (align),
      .we     (we),
      .div_in (cfg_div),
      .ce_p   (ce_p[i]),
      .ce_n   (ce_n[i]),
      .busy   (cfg_busy[i])
    );
  end

endmodule

// File: tb/tb_lynx_ce_gen.sv
// Directed scoreboard bench for lynx_ce_gen: each phase pushes the expected
// strobe and cfg_busy events per edge; a negedge monitor matches them.
module tb_lynx_ce_gen;

  localparam int W = 21;  // {cycle[15:0], kind[1:0], val, ch[1:0]}

  logic       clock;
  logic       reset;
  logic [2:0] stall;
  logic       align;
  logic       cfg_we;
  logic [1:0] cfg_sel;
  logic [5:0] cfg_div;
  logic [2:0] ce_p;
  logic [2:0] ce_n;
  logic [2:0] cfg_busy;

  lynx_ce_gen dut (
    .clock    (clock),
    .reset    (reset),
    .stall    (stall),
    .align    (align),
    .cfg_we   (cfg_we),
    .cfg_sel  (cfg_sel),
    .cfg_div  (cfg_div),
    .ce_p     (ce_p),
    .ce_n     (ce_n),
    .cfg_busy (cfg_busy)
  );

  // ---------------- clock / reset / edge counter ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc;
  always @(posedge clock or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int   n_cmp;
  int   n_err;
  logic mon_en;
  int   watch_end;
  logic [2:0] watch_p;
  logic [2:0] watch_n;

  function automatic logic [W-1:0] mk(input int c, input int k, input int ch, input logic v);
    return {c[15:0], k[1:0], v, ch[1:0]};
  endfunction

  task automatic push_seq(input int k, input int ch, input int first, input int period, input int last);
    for (int c = first; c <= last; c += period) exp_q.push_back(mk(c, k, ch, 1'b1));
  endtask

  task automatic push_busy(input int c, input int ch, input logic v);
    exp_q.push_back(mk(c, 2, ch, v));
  endtask

  task automatic check_val(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drain;
    while (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL missed event: cycle %0d kind %0d ch %0d val %0b never observed",
               exp_q[0][20:5], exp_q[0][4:3], exp_q[0][1:0], exp_q[0][2]);
      void'(exp_q.pop_front());
    end
  endtask

  // ---------------- monitor ----------------
  logic found;
  logic act;
  int   idx;

  always @(negedge clock) begin
    if (reset && mon_en && cyc >= 1 && cyc <= watch_end) begin
      for (int k = 0; k < 2; k++) begin
        for (int ch = 0; ch < 3; ch++) begin
          if ((k == 0) ? watch_p[ch] : watch_n[ch]) begin
            act   = (k == 0) ? ce_p[ch] : ce_n[ch];
            found = 1'b0;
            idx   = 0;
            for (int i = 0; i < exp_q.size(); i++) begin
              if (!found && exp_q[i] == mk(cyc, k, ch, 1'b1)) begin
                found = 1'b1;
                idx   = i;
              end
            end
            if (act || found) begin
              n_cmp++;
              if (act !== found) begin
                n_err++;
                $display("FAIL strobe %s[%0d] at edge %0d: got %0b expected %0b",
                         (k == 0) ? "ce_p" : "ce_n", ch, cyc, act, found);
              end
              if (found) exp_q.delete(idx);
            end
          end
        end
      end
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i][4:3] == 2'd2 && exp_q[i][20:5] == cyc[15:0]) begin
          n_cmp++;
          if (cfg_busy[exp_q[i][1:0]] !== exp_q[i][2]) begin
            n_err++;
            $display("FAIL cfg_busy[%0d] at edge %0d: got %0b expected %0b",
                     exp_q[i][1:0], cyc, cfg_busy[exp_q[i][1:0]], exp_q[i][2]);
          end
          exp_q.delete(i);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic go_to(input int n);
    while (cyc < n) @(negedge clock);
  endtask

  task automatic start_phase(input int last, input logic [2:0] wp, input logic [2:0] wn);
    drain();
    repeat (2) @(negedge clock);
    watch_p   = wp;
    watch_n   = wn;
    watch_end = last;
    reset     = 1'b1;
    mon_en    = 1'b1;
  endtask

  task automatic finish_phase(input int last);
    go_to(last + 1);
    mon_en = 1'b0;
    reset  = 1'b0;
  endtask

  // Drives a write that the DUT samples at edge e.
  task automatic wr(input int sel, input int div, input int e);
    go_to(e - 1);
    cfg_we  = 1'b1;
    cfg_sel = sel[1:0];
    cfg_div = div[5:0];
    go_to(e);
    cfg_we  = 1'b0;
  endtask

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0; n_err = 0; mon_en = 1'b0; watch_end = 0;
    watch_p = '0; watch_n = '0;
    reset = 1'b0; stall = '0; align = 1'b0;
    cfg_we = 1'b0; cfg_sel = '0; cfg_div = '0;

    #12;
    check_val("reset ce_p", ce_p, 3'b000);
    check_val("reset ce_n", ce_n, 3'b000);
    check_val("reset cfg_busy", cfg_busy, 3'b000);

    // Defaults: /8, /64, /12
    start_phase(128, 3'b111, 3'b111);
    push_seq(0, 0, 8, 8, 128);   push_seq(1, 0, 4, 8, 128);
    push_seq(0, 1, 64, 64, 128); push_seq(1, 1, 32, 64, 128);
    push_seq(0, 2, 12, 12, 128); push_seq(1, 2, 6, 12, 128);
    for (int ch = 0; ch < 3; ch++) begin
      push_busy(1, ch, 1'b0);
      push_busy(128, ch, 1'b0);
    end
    finish_phase(128);

    // Reprogram ch2 to /6 at cnt=3; out-of-range select ignored
    start_phase(48, 3'b100, 3'b100);
    push_seq(0, 2, 12, 6, 48);
    push_seq(1, 2, 6, 6, 6);     push_seq(1, 2, 15, 6, 48);
    push_busy(3, 2, 1'b0); push_busy(4, 2, 1'b1);
    push_busy(11, 2, 1'b1); push_busy(12, 2, 1'b0);
    for (int ch = 0; ch < 3; ch++) push_busy(31, ch, 1'b0);
    wr(2, 5, 4);
    wr(3, 0, 30);
    finish_phase(48);

    // Write ch0 /4 on its wrap edge
    start_phase(40, 3'b001, 3'b001);
    push_seq(0, 0, 8, 8, 16);    push_seq(0, 0, 20, 4, 40);
    push_seq(1, 0, 4, 8, 12);    push_seq(1, 0, 18, 4, 40);
    push_busy(7, 0, 1'b0); push_busy(8, 0, 1'b1);
    push_busy(15, 0, 1'b1); push_busy(16, 0, 1'b0);
    wr(0, 3, 8);
    finish_phase(40);

    // Stall ch2 for edges 15..19
    start_phase(56, 3'b100, 3'b100);
    push_seq(0, 2, 12, 12, 12);  push_seq(0, 2, 29, 12, 56);
    push_seq(1, 2, 6, 6, 6);     push_seq(1, 2, 23, 12, 56);
    go_to(14);
    stall = 3'b100;
    go_to(19);
    stall = 3'b000;
    finish_phase(56);

    // Align at edge 20 with ch1 write pending
    start_phase(88, 3'b111, 3'b111);
    push_seq(0, 0, 8, 8, 16);    push_seq(0, 0, 28, 8, 88);
    push_seq(1, 0, 4, 8, 12);    push_seq(1, 0, 24, 8, 88);
    push_seq(0, 1, 52, 32, 88);  push_seq(1, 1, 36, 32, 88);
    push_seq(0, 2, 12, 12, 12);  push_seq(0, 2, 32, 12, 88);
    push_seq(1, 2, 6, 12, 18);   push_seq(1, 2, 26, 12, 88);
    push_busy(9, 1, 1'b0); push_busy(10, 1, 1'b1);
    push_busy(19, 1, 1'b1);
    for (int ch = 0; ch < 3; ch++) push_busy(20, ch, 1'b0);
    wr(1, 31, 10);
    go_to(19);
    align = 1'b1;
    go_to(20);
    align = 1'b0;
    finish_phase(88);

    // Divisor 0 on ch0: both strobes every clock after the applying wrap
    start_phase(20, 3'b001, 3'b001);
    push_seq(0, 0, 8, 1, 20);
    push_seq(1, 0, 4, 4, 4);     push_seq(1, 0, 9, 1, 20);
    push_busy(2, 0, 1'b1); push_busy(7, 0, 1'b1); push_busy(8, 0, 1'b0);
    wr(0, 0, 2);
    finish_phase(20);

    // Reset mid-run with ch1 pending
    start_phase(8, 3'b001, 3'b001);
    push_seq(0, 0, 8, 8, 8);     push_seq(1, 0, 4, 4, 4);
    push_busy(3, 1, 1'b1); push_busy(8, 1, 1'b1);
    wr(1, 31, 3);
    go_to(8);
    #2;
    reset = 1'b0;
    #1;
    check_val("async reset ce_p", ce_p, 3'b000);
    check_val("async reset ce_n", ce_n, 3'b000);
    check_val("async reset cfg_busy", cfg_busy, 3'b000);
    start_phase(130, 3'b011, 3'b011);
    push_seq(0, 0, 8, 8, 130);   push_seq(1, 0, 4, 8, 130);
    push_seq(0, 1, 64, 64, 130); push_seq(1, 1, 32, 64, 130);
    push_busy(1, 1, 1'b0); push_busy(40, 1, 1'b0); push_busy(70, 1, 1'b0);
    finish_phase(130);

    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
